// File: rtl/minesweeper_board_ctrl_pkg.sv
// Shared types for the 8x8 Buscaminas board engine.
// Board bit [r][c] is packed bit r*8+c.
package minesweeper_pkg;

  localparam int BOARD_N = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    FLOOD,
    LOST,
    WON
  } state_t;

  typedef logic [2:0] coord_t;
  typedef logic [BOARD_N-1:0][BOARD_N-1:0] board_t;
  typedef logic [3:0] count_t;
  typedef count_t [BOARD_N-1:0][BOARD_N-1:0] count_board_t;

endpackage

// File: rtl/minesweeper_board_ctrl_adjacency.sv
// Per-cell count of mines among the in-bounds neighbours.
// Shared with the painter for number display.
module mine_adjacency_counter
  import minesweeper_pkg::*;
(
  input  board_t       mines,
  output count_board_t counts
);

  // One-cell zero border so edge cells need no bounds checks
  logic [BOARD_N+1:0][BOARD_N+1:0] pad;

  always_comb begin
    pad = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        pad[r+1][c+1] = mines[r][c];
  end

  always_comb begin
    counts = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (!(i == 1 && j == 1))
              counts[r][c] = counts[r][c]
                + count_t'(pad[r+i][c+j]);
  end

endmodule

// File: rtl/minesweeper_board_ctrl.sv
// Game-state engine: mine map, cursor, flags, reveals and
// ring-per-cycle flood fill; drives the VGA cell_matrix.
module minesweeper_board_ctrl
  import minesweeper_pkg::*;
#(
  parameter int N         = BOARD_N,
  parameter int FLOOD_MAX = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0][N-1:0]  mine_map,
  input  logic                 mv_up,
  input  logic                 mv_down,
  input  logic                 mv_left,
  input  logic                 mv_right,
  input  logic                 act_reveal,
  input  logic                 act_flag,
  output logic [N-1:0][N-1:0]  cell_matrix,
  output logic [N-1:0][N-1:0]  flag_matrix,
  output logic [$clog2(N)-1:0] cursor_row,
  output logic [$clog2(N)-1:0] cursor_col,
  output logic                 busy,
  output logic                 game_over,
  output logic                 game_won
);

  localparam int CW = $clog2(N);
  localparam int FW = $clog2(FLOOD_MAX + 1);

  state_t       state;
  board_t       mines;
  count_board_t counts;
  logic [FW-1:0] flood_cnt;

  board_t sel;
  board_t rev_next;
  board_t grow;
  board_t flood_next;
  logic [BOARD_N+1:0][BOARD_N+1:0] zp;
  logic cur_mine;
  logic cur_rev;
  logic cur_flag;
  logic cur_zero;

  mine_adjacency_counter u_adj (
    .mines  (mines),
    .counts (counts)
  );

  always_comb begin
    sel = '0;
    sel[cursor_row][cursor_col] = 1'b1;
    rev_next = cell_matrix | sel;
    cur_mine = mines[cursor_row][cursor_col];
    cur_rev  = cell_matrix[cursor_row][cursor_col];
    cur_flag = flag_matrix[cursor_row][cursor_col];
    cur_zero = counts[cursor_row][cursor_col] == '0;
  end

  // Revealed zero cells spread into every eligible neighbour
  always_comb begin
    zp = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        zp[r+1][c+1] = cell_matrix[r][c] & ~mines[r][c]
                     & (counts[r][c] == '0);
    grow = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            grow[r][c] = grow[r][c] | zp[r+i][c+j];
    grow = grow & ~cell_matrix & ~flag_matrix & ~mines;
    flood_next = cell_matrix | grow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mines       <= '0;
      cell_matrix <= '0;
      flag_matrix <= '0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
      flood_cnt   <= '0;
    end else if (start) begin
      state       <= LOAD;
      mines       <= mine_map;
      cell_matrix <= '0;
      flag_matrix <= '0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      busy        <= 1'b1;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, LOST, WON: begin
        end
        LOAD: begin
          state <= PLAY;
          busy  <= 1'b0;
        end
        PLAY: begin
          if (&(cell_matrix | mines)) begin
            state    <= WON;
            game_won <= 1'b1;
          end else if (act_reveal) begin
            if (!cur_rev && !cur_flag) begin
              if (cur_mine) begin
                state       <= LOST;
                game_over   <= 1'b1;
                cell_matrix <= cell_matrix | mines;
              end else if (&(rev_next | mines)) begin
                state       <= WON;
                game_won    <= 1'b1;
                cell_matrix <= rev_next;
              end else if (cur_zero) begin
                state       <= FLOOD;
                busy        <= 1'b1;
                flood_cnt   <= '0;
                cell_matrix <= rev_next;
              end else begin
                cell_matrix <= rev_next;
              end
            end
          end else if (act_flag) begin
            if (!cur_rev)
              flag_matrix <= flag_matrix ^ sel;
          end else if (mv_up) begin
            if (cursor_row != '0)
              cursor_row <= cursor_row - 1'b1;
          end else if (mv_down) begin
            if (cursor_row != CW'(N - 1))
              cursor_row <= cursor_row + 1'b1;
          end else if (mv_left) begin
            if (cursor_col != '0)
              cursor_col <= cursor_col - 1'b1;
          end else if (mv_right) begin
            if (cursor_col != CW'(N - 1))
              cursor_col <= cursor_col + 1'b1;
          end
        end
        FLOOD: begin
          cell_matrix <= flood_next;
          flood_cnt   <= flood_cnt + 1'b1;
          if (grow == '0 || flood_cnt == FW'(FLOOD_MAX - 1)) begin
            busy <= 1'b0;
            if (&(flood_next | mines)) begin
              state    <= WON;
              game_won <= 1'b1;
            end else begin
              state <= PLAY;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minesweeper_board_ctrl.sv
// Directed bench for minesweeper_board_ctrl with a BFS-based
// game model checked every cycle plus literal pins.
module tb_minesweeper_board_ctrl;

  localparam int FMAX = 64;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_FLOOD = 3;
  localparam int M_LOST  = 4;
  localparam int M_WON   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0][7:0] mine_map = '0;
  logic mv_up = 1'b0;
  logic mv_down = 1'b0;
  logic mv_left = 1'b0;
  logic mv_right = 1'b0;
  logic act_reveal = 1'b0;
  logic act_flag = 1'b0;
  logic [7:0][7:0] cell_matrix;
  logic [7:0][7:0] flag_matrix;
  logic [2:0] cursor_row;
  logic [2:0] cursor_col;
  logic busy;
  logic game_over;
  logic game_won;

  minesweeper_board_ctrl #(
    .N         (8),
    .FLOOD_MAX (FMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mine_map    (mine_map),
    .mv_up       (mv_up),
    .mv_down     (mv_down),
    .mv_left     (mv_left),
    .mv_right    (mv_right),
    .act_reveal  (act_reveal),
    .act_flag    (act_flag),
    .cell_matrix (cell_matrix),
    .flag_matrix (flag_matrix),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .busy        (busy),
    .game_over   (game_over),
    .game_won    (game_won)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  bit m_mine[8][8];
  bit m_rev[8][8];
  bit m_flag[8][8];
  int m_dist[8][8];
  int m_r, m_c, m_mode, m_j;
  bit m_over, m_won;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bit inb(int r, int c);
    return r >= 0 && r < 8 && c >= 0 && c < 8;
  endfunction

  function automatic int adj(int r, int c);
    int n;
    int rr;
    int cc;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if ((dr != 0 || dc != 0) && inb(rr, cc))
          if (m_mine[rr][cc]) n++;
      end
    return n;
  endfunction

  function automatic bit all_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (!m_mine[r][c] && !m_rev[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] pack(int which);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[r*8+c] = (which == 0) ? m_rev[r][c] : m_flag[r][c];
    return v;
  endfunction

  // Flood as breadth-first layers: cell at distance d appears
  // on the d-th flood cycle.
  task automatic flood_plan();
    int q[$];
    int p, r, c, rr, cc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        m_dist[i][j] = -1;
        if (m_rev[i][j] && !m_mine[i][j] && adj(i, j) == 0) begin
          m_dist[i][j] = 0;
          q.push_back(i * 8 + j);
        end
      end
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / 8;
      c = p % 8;
      if (adj(r, c) == 0)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (inb(rr, cc))
              if (m_dist[rr][cc] == -1 && !m_rev[rr][cc]
                  && !m_flag[rr][cc] && !m_mine[rr][cc]) begin
                m_dist[rr][cc] = m_dist[r][c] + 1;
                q.push_back(rr * 8 + cc);
              end
          end
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        m_mine[r][c] = 0;
        m_rev[r][c] = 0;
        m_flag[r][c] = 0;
      end
    m_r = 0;
    m_c = 0;
    m_mode = M_IDLE;
    m_j = 0;
    m_over = 0;
    m_won = 0;
  endtask

  task automatic model_step();
    bit any;
    if (rst) begin
      model_reset();
      return;
    end
    if (start) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          m_mine[r][c] = mine_map[r][c];
          m_rev[r][c] = 0;
          m_flag[r][c] = 0;
        end
      m_r = 0;
      m_c = 0;
      m_over = 0;
      m_won = 0;
      m_mode = M_LOAD;
      return;
    end
    case (m_mode)
      M_LOAD: m_mode = M_PLAY;
      M_PLAY: begin
        if (all_clear()) begin
          m_mode = M_WON;
          m_won = 1;
        end else if (act_reveal) begin
          if (!m_rev[m_r][m_c] && !m_flag[m_r][m_c]) begin
            m_rev[m_r][m_c] = 1;
            if (m_mine[m_r][m_c]) begin
              m_mode = M_LOST;
              m_over = 1;
              for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                  if (m_mine[r][c]) m_rev[r][c] = 1;
            end else if (all_clear()) begin
              m_mode = M_WON;
              m_won = 1;
            end else if (adj(m_r, m_c) == 0) begin
              flood_plan();
              m_j = 0;
              m_mode = M_FLOOD;
            end
          end
        end else if (act_flag) begin
          if (!m_rev[m_r][m_c]) m_flag[m_r][m_c] = !m_flag[m_r][m_c];
        end else if (mv_up) begin
          if (m_r > 0) m_r--;
        end else if (mv_down) begin
          if (m_r < 7) m_r++;
        end else if (mv_left) begin
          if (m_c > 0) m_c--;
        end else if (mv_right) begin
          if (m_c < 7) m_c++;
        end
      end
      M_FLOOD: begin
        any = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            if (m_dist[r][c] == m_j + 1) begin
              m_rev[r][c] = 1;
              any = 1;
            end
        if (!any || m_j == FMAX - 1) begin
          if (all_clear()) begin
            m_mode = M_WON;
            m_won = 1;
          end else begin
            m_mode = M_PLAY;
          end
        end
        m_j++;
      end
      default: begin
      end
    endcase
  endtask

  task automatic compare_model();
    check("cells", cell_matrix, pack(0));
    check("flags", flag_matrix, pack(1));
    check("cursor", 64'({cursor_row, cursor_col}), 64'(m_r * 8 + m_c));
    check("busy", 64'(busy), 64'(m_mode == M_LOAD || m_mode == M_FLOOD));
    check("game_over", 64'(game_over), 64'(m_over));
    check("game_won", 64'(game_won), 64'(m_won));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    start = 0;
    mv_up = 0;
    mv_down = 0;
    mv_left = 0;
    mv_right = 0;
    act_reveal = 0;
    act_flag = 0;
    compare_model();
  endtask

  task automatic wait_idle(input int lim, output int k);
    k = 0;
    while (busy === 1'b1 && k < lim) begin
      tick();
      k++;
    end
    check("busy_bound", 64'(busy), 64'd0);
  endtask

  initial begin
    int k;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("rst_cells", cell_matrix, 64'd0);
    check("rst_flags", flag_matrix, 64'd0);
    check("rst_status", 64'({busy, game_over, game_won}), 64'd0);
    rst = 0;

    act_reveal = 1; mv_down = 1; tick();
    act_flag = 1; mv_right = 1; tick();
    check("idle_cursor", 64'({cursor_row, cursor_col}), 64'd0);

    // single corner mine, flood from the opposite corner
    mine_map = '0; mine_map[0][0] = 1'b1;
    start = 1; tick();
    check("load_busy", 64'(busy), 64'd1);
    tick();
    repeat (7) begin mv_down = 1; tick(); end
    repeat (7) begin mv_right = 1; tick(); end
    check("s1_cursor", 64'({cursor_row, cursor_col}), 64'h3F);
    act_reveal = 1; tick();
    check("s1_flood_entry", 64'(busy), 64'd1);
    wait_idle(200, k);
    check("s1_flood_cycles", 64'(k), 64'd8);
    check("s1_cells", cell_matrix, 64'hFFFF_FFFF_FFFF_FFFE);
    check("s1_model_cells", pack(0), 64'hFFFF_FFFF_FFFF_FFFE);
    check("s1_won", 64'({game_won, game_over}), 64'b10);
    mv_up = 1; tick();
    act_flag = 1; tick();
    check("s1_frozen", 64'({cursor_row, cursor_col}), 64'h3F);

    // hit a mine
    mine_map = '0; mine_map[3][3] = 1'b1;
    start = 1; tick();
    tick();
    repeat (3) begin mv_down = 1; tick(); end
    repeat (3) begin mv_right = 1; tick(); end
    act_reveal = 1; tick();
    check("s2_cells", cell_matrix, 64'h0000_0000_0800_0000);
    check("s2_lost", 64'({game_won, game_over}), 64'b01);
    mv_down = 1; tick();
    act_flag = 1; tick();
    check("s2_held", 64'({cursor_row, cursor_col}), 64'h1B);

    // numbered cell, clamps, flags, priority, reset mid-flood
    mine_map = '0; mine_map[0][1] = 1'b1; mine_map[1][0] = 1'b1;
    start = 1; tick();
    tick();
    act_reveal = 1; tick();
    check("s3_cells", cell_matrix, 64'd1);
    check("s3_busy", 64'(busy), 64'd0);
    mv_up = 1; tick();
    mv_left = 1; tick();
    check("clamp_ul", 64'({cursor_row, cursor_col}), 64'd0);
    repeat (8) begin mv_right = 1; tick(); end
    check("clamp_right", 64'(cursor_col), 64'd7);
    repeat (5) begin mv_left = 1; tick(); end
    repeat (2) begin mv_down = 1; tick(); end
    check("s3_cursor", 64'({cursor_row, cursor_col}), 64'h12);
    act_flag = 1; tick();
    check("flag_set", flag_matrix, 64'h0000_0000_0004_0000);
    act_reveal = 1; tick();
    check("flag_blocks", cell_matrix, 64'd1);
    act_flag = 1; tick();
    check("flag_clear", flag_matrix, 64'd0);
    act_reveal = 1; mv_down = 1; tick();
    check("prio_cursor", 64'({cursor_row, cursor_col}), 64'h12);
    check("prio_cells", cell_matrix, 64'h0000_0000_0004_0001);
    tick();
    tick();
    check("mid_flood", 64'(busy), 64'd1);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("arst_cells", cell_matrix, 64'd0);
    check("arst_flags", flag_matrix, 64'd0);
    check("arst_cursor", 64'({cursor_row, cursor_col}), 64'd0);
    check("arst_status", 64'({busy, game_over, game_won}), 64'd0);
    tick();
    rst = 0;

    // start beats a same-cycle reveal
    mine_map = '0; mine_map[5][5] = 1'b1;
    start = 1; act_reveal = 1; tick();
    check("st_rev_busy", 64'(busy), 64'd1);
    check("st_rev_cells", cell_matrix, 64'd0);
    tick();
    check("st_rev_play", 64'({busy, game_over, game_won}), 64'd0);
    check("st_rev_cells2", cell_matrix, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
